// File: rtl/lock_pkg.sv
// Shared widths, state encoding and factory password for the code lock.
package lock_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned NUM_W   = 6 * DIGIT_W;

   localparam logic [NUM_W-1:0] DEFAULT_PWD = 24'h123456;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StOpen    = 3'd1,
      StError   = 3'd2,
      StLockout = 3'd3,
      StSet     = 3'd4
   } lock_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by all timed lock states; expire is high while the count is 0.
module lock_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] value,
   output logic             expire
);

   logic [WIDTH-1:0] value_q;

   // Saturates at zero so an idle timer never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_val;
      end else if (value_q != '0) begin
         value_q <= value_q - 1'b1;
      end
   end

   assign value  = value_q;
   assign expire = (value_q == '0);

endmodule

// File: rtl/lock_check.sv
// Code-lock checker FSM. Define LOCK_CHANGE_PWD_EN to allow password change from the OPEN state.
module lock_check
   import lock_pkg::*;
#(
   parameter logic [NUM_W-1:0] DEFAULT_PWD = lock_pkg::DEFAULT_PWD,
   parameter int unsigned      MAX_FAIL    = 3,
   parameter int unsigned      OPEN_CYCLES = 50_000_000,
   parameter int unsigned      ERR_CYCLES  = 25_000_000,
   parameter int unsigned      LOCK_CYCLES = 500_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_W-1:0] number,
   input  logic             wordin_out_flag,
   input  logic             change_req,
   output logic             unlock,
   output logic             err,
   output logic             alarm,
   output logic             pwd_changed,
   output logic [2:0]       fail_cnt,
   output logic [2:0]       state_o
);

   localparam int unsigned MAX_CYC = max3(OPEN_CYCLES, ERR_CYCLES, LOCK_CYCLES);
   localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
   localparam logic [2:0]  MAX_F   = 3'(MAX_FAIL);

   // Timer holds N-1 on entry so the state lasts exactly N cycles up to expiry.
   localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] ERR_LD  = TMR_W'(ERR_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LD = TMR_W'(LOCK_CYCLES - 1);

   lock_state_t      state_q, state_d;
   logic [2:0]       fail_q, fail_d;
   logic [2:0]       fail_inc;
   logic             unlock_q, err_q, alarm_q;
   logic [NUM_W-1:0] pwd;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic [TMR_W-1:0] tmr_value;
   logic             tmr_expire;

`ifdef LOCK_CHANGE_PWD_EN
   logic [NUM_W-1:0] pwd_q, pwd_d;
   logic             pwd_changed_q, pwd_changed_d;
`endif

   lock_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .value    (tmr_value),
      .expire   (tmr_expire)
   );

   assign fail_inc = fail_q + 3'd1;

   always_comb begin
      state_d      = state_q;
      fail_d       = fail_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
`ifdef LOCK_CHANGE_PWD_EN
      pwd_d         = pwd_q;
      pwd_changed_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (wordin_out_flag) begin
               tmr_load = 1'b1;
               if (number == pwd) begin
                  state_d      = StOpen;
                  fail_d       = 3'd0;
                  tmr_load_val = OPEN_LD;
               end else begin
                  fail_d = fail_inc;
                  if (fail_inc == MAX_F) begin
                     state_d      = StLockout;
                     tmr_load_val = LOCK_LD;
                  end else begin
                     state_d      = StError;
                     tmr_load_val = ERR_LD;
                  end
               end
            end
         end
         StOpen: begin
            if (tmr_expire) begin
               state_d = StIdle;
`ifdef LOCK_CHANGE_PWD_EN
            end else if (change_req) begin
               state_d      = StSet;
               tmr_load     = 1'b1;
               tmr_load_val = OPEN_LD;
`endif
            end
         end
         StError: begin
            if (tmr_expire) state_d = StIdle;
         end
         StLockout: begin
            if (tmr_expire) begin
               state_d = StIdle;
               fail_d  = 3'd0;
            end
         end
`ifdef LOCK_CHANGE_PWD_EN
         StSet: begin
            if (tmr_expire) begin
               state_d = StIdle;
            end else if (wordin_out_flag) begin
               state_d       = StIdle;
               pwd_d         = number;
               pwd_changed_d = 1'b1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Outputs are flopped from the next state so they change with state_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         fail_q   <= 3'd0;
         unlock_q <= 1'b0;
         err_q    <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         fail_q   <= fail_d;
         unlock_q <= (state_d == StOpen);
         err_q    <= (state_d == StError);
         alarm_q  <= (state_d == StLockout);
      end
   end

`ifdef LOCK_CHANGE_PWD_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwd_q         <= DEFAULT_PWD;
         pwd_changed_q <= 1'b0;
      end else begin
         pwd_q         <= pwd_d;
         pwd_changed_q <= pwd_changed_d;
      end
   end

   assign pwd         = pwd_q;
   assign pwd_changed = pwd_changed_q;
`else
   logic unused_change_req;
   assign unused_change_req = change_req;
   assign pwd               = DEFAULT_PWD;
   assign pwd_changed       = 1'b0;
`endif

   logic [TMR_W-1:0] unused_tmr_value;
   assign unused_tmr_value = tmr_value;

   assign unlock   = unlock_q;
   assign err      = err_q;
   assign alarm    = alarm_q;
   assign fail_cnt = fail_q;
   assign state_o  = state_q;

endmodule
